// File: rtl/traffic_phase_controller.sv
// Two-road intersection phase sequencer. A Moore FSM walks the six lamp
// phases. It arms the external phase timer on entry to each phase, then
// waits for that timer's expiry. A latched side-road request decides whether
// the side phase is served after a main-green expiry.
module traffic_phase_controller #(
   parameter int unsigned T_MAIN_GREEN = 8,
   parameter int unsigned T_SIDE_GREEN = 5,
   parameter int unsigned T_YELLOW     = 3,
   parameter int unsigned T_ALLRED     = 1
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       side_request,
   input  logic       expired,
   output logic [3:0] timer_value,
   output logic       start_timer,
   output logic       seconds_enabled,
   output logic [2:0] main_light,
   output logic [2:0] side_light
);

   // A phase of length 0 would never arm a meaningful count, so 0 becomes 1.
   // Values beyond the 4-bit timer range saturate instead of wrapping.
   function automatic logic [3:0] clamp_phase(input int unsigned v);
      if (v == 0)       return 4'd1;
      else if (v > 15)  return 4'd15;
      else              return v[3:0];
   endfunction

   localparam logic [3:0] MAIN_GREEN_T = clamp_phase(T_MAIN_GREEN);
   localparam logic [3:0] SIDE_GREEN_T = clamp_phase(T_SIDE_GREEN);
   localparam logic [3:0] YELLOW_T     = clamp_phase(T_YELLOW);
   localparam logic [3:0] ALLRED_T     = clamp_phase(T_ALLRED);

   localparam logic [2:0] MAIN_GREEN  = 3'd0;
   localparam logic [2:0] MAIN_YELLOW = 3'd1;
   localparam logic [2:0] ALL_RED_1   = 3'd2;
   localparam logic [2:0] SIDE_GREEN  = 3'd3;
   localparam logic [2:0] SIDE_YELLOW = 3'd4;
   localparam logic [2:0] ALL_RED_2   = 3'd5;

   // Lamp encoding is {red, yellow, green}.
   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   logic [2:0] state, state_next;
   logic       arm, arm_next;         // 1 during the single ARM cycle of a phase
   logic       req_pending, req_next;
   logic [2:0] main_next, side_next;
   logic [3:0] value_next;
   logic       leave;

   // Expiry only counts in WAIT. The ARM cycle ignores whatever the timer shows.
   assign leave = !arm && expired;

   // The timer always counts whole seconds.
   assign seconds_enabled = 1'b1;

   // start_timer is the registered ARM flag itself, so it pulses for exactly
   // one cycle after every entry, including a self-loop.
   assign start_timer = arm;

   // Next-state logic: advance on expiry in WAIT, otherwise fall out of ARM.
   always_comb begin
      // NOTE: defaults first, so every path assigns every output and no latch is inferred.
      state_next = state;
      arm_next   = 1'b0;
      case (state)
         MAIN_GREEN: if (leave) begin
            state_next = req_pending ? MAIN_YELLOW : MAIN_GREEN;
            arm_next   = 1'b1;
         end
         MAIN_YELLOW: if (leave) begin state_next = ALL_RED_1;   arm_next = 1'b1; end
         ALL_RED_1:   if (leave) begin state_next = SIDE_GREEN;  arm_next = 1'b1; end
         SIDE_GREEN:  if (leave) begin state_next = SIDE_YELLOW; arm_next = 1'b1; end
         SIDE_YELLOW: if (leave) begin state_next = ALL_RED_2;   arm_next = 1'b1; end
         ALL_RED_2:   if (leave) begin state_next = MAIN_GREEN;  arm_next = 1'b1; end
         default: begin
            // Unreachable encodings fall back to the safe all-red phase.
            state_next = ALL_RED_2;
            arm_next   = 1'b1;
         end
      endcase
   end

   // Request latch. It clears on entry to side green, and the clear beats a request on that same edge.
   always_comb begin
      if (state_next == SIDE_GREEN && arm_next) req_next = 1'b0;
      else                                      req_next = req_pending | side_request;
   end

   // Decode lamps and phase duration from the next state, so that they register alongside it.
   always_comb begin
      main_next  = RED;
      side_next  = RED;
      value_next = ALLRED_T;
      case (state_next)
         MAIN_GREEN:  begin main_next = GREEN;  value_next = MAIN_GREEN_T; end
         MAIN_YELLOW: begin main_next = YELLOW; value_next = YELLOW_T;     end
         SIDE_GREEN:  begin side_next = GREEN;  value_next = SIDE_GREEN_T; end
         SIDE_YELLOW: begin side_next = YELLOW; value_next = YELLOW_T;     end
         default:     ; // all-red phases use the defaults above
      endcase
   end

   // State and output registers. Reset parks the controller in armed all-red, which keeps the timer cleared.
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state       <= ALL_RED_2;
         arm         <= 1'b1;
         req_pending <= 1'b0;
         timer_value <= ALLRED_T;
         main_light  <= RED;
         side_light  <= RED;
      end else begin
         // NOTE: non-blocking assignments, so every register sees the pre-edge values of the others.
         state       <= state_next;
         arm         <= arm_next;
         req_pending <= req_next;
         timer_value <= value_next;
         main_light  <= main_next;
         side_light  <= side_next;
      end
   end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller. A behavioural phase timer
// sits beside the DUT, and each scenario checks phase lengths and lamps.
module tb_traffic_phase_controller;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   logic       clkin = 1'b0;
   logic       reset = 1'b1;
   logic       side_request = 1'b0;
   logic       expired;
   logic [3:0] timer_value;
   logic       start_timer;
   logic       seconds_enabled;
   logic [2:0] main_light;
   logic [2:0] side_light;

   int   checks = 0;
   int   errors = 0;
   int   unsafe_cycles = 0;
   int   side_nonred = 0;
   logic force_mode = 1'b0;
   logic forced_exp = 1'b0;
   logic hold_req = 1'b0;
   logic [3:0] tcount;

   traffic_phase_controller dut (
      .clkin           (clkin),
      .reset           (reset),
      .side_request    (side_request),
      .expired         (expired),
      .timer_value     (timer_value),
      .start_timer     (start_timer),
      .seconds_enabled (seconds_enabled),
      .main_light      (main_light),
      .side_light      (side_light)
   );

   always #5 clkin = ~clkin;

   // Companion timer model. start_timer is an async restart. The count
   // saturates at 15, and expired shows once the count reaches timer_value.
   always @(posedge clkin or posedge start_timer) begin
      if (start_timer)                           tcount <= 4'd0;
      else if (seconds_enabled && tcount != 4'hF) tcount <= tcount + 4'd1;
   end

   assign expired = force_mode ? forced_exp : (!start_timer && (tcount >= timer_value));

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock. Sample 1 time unit after the edge and track lamp safety.
   task automatic step();
      @(posedge clkin);
      #1;
      if (main_light[2] == 1'b0 && side_light[2] == 1'b0) unsafe_cycles++;
      if (side_light !== R) side_nonred++;
   endtask

   // Start right after a phase entry and run to the next entry (start_timer seen high).
   // len is the number of edges taken. req_at pulses side_request on that edge of the phase.
   task automatic next_phase(input int req_at, output int len, output logic first_start);
      len = 0;
      first_start = 1'b1;
      do begin
         len++;
         side_request = hold_req || (len == req_at);
         step();
         if (len == 1) first_start = start_timer;
      end while (start_timer !== 1'b1 && len < 40);
      side_request = hold_req;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (5) step();
      checks++; if (main_light !== R)      begin errors++; $display("FAIL reset_main: got %b expected %b", main_light, R); end
      checks++; if (side_light !== R)      begin errors++; $display("FAIL reset_side: got %b expected %b", side_light, R); end
      checks++; if (start_timer !== 1'b1)  begin errors++; $display("FAIL reset_start: got %b expected 1", start_timer); end
      checks++; if (timer_value !== 4'd1)  begin errors++; $display("FAIL reset_value: got %0d expected 1", timer_value); end
      checks++; if (seconds_enabled !== 1'b1) begin errors++; $display("FAIL reset_seconds: got %b expected 1", seconds_enabled); end
   endtask

   task automatic test_no_request();
      int   len;
      logic s1;
      unsafe_cycles = 0;
      side_nonred = 0;
      reset = 1'b0;
      next_phase(0, len, s1);
      checks++; if (len !== 3)            begin errors++; $display("FAIL norq_first_len: got %0d expected 3", len); end
      checks++; if (main_light !== G)     begin errors++; $display("FAIL norq_first_main: got %b expected %b", main_light, G); end
      checks++; if (timer_value !== 4'd8) begin errors++; $display("FAIL norq_first_value: got %0d expected 8", timer_value); end
      for (int i = 0; i < 10; i++) begin
         next_phase(0, len, s1);
         checks++; if (len !== 10)        begin errors++; $display("FAIL norq_len[%0d]: got %0d expected 10", i, len); end
         checks++; if (main_light !== G)  begin errors++; $display("FAIL norq_main[%0d]: got %b expected %b", i, main_light, G); end
      end
      checks++; if (side_nonred !== 0)   begin errors++; $display("FAIL norq_side_nonred: got %0d expected 0", side_nonred); end
      checks++; if (unsafe_cycles !== 0) begin errors++; $display("FAIL norq_unsafe: got %0d expected 0", unsafe_cycles); end
   endtask

   task automatic test_single_request();
      int         req_at [7] = '{4, 0, 0, 0, 0, 0, 0};
      int         exp_len[7] = '{10, 5, 3, 7, 5, 3, 10};
      logic [2:0] exp_m  [7] = '{Y, R, R, R, R, G, G};
      logic [2:0] exp_s  [7] = '{R, R, G, Y, R, R, R};
      logic [3:0] exp_v  [7] = '{4'd3, 4'd1, 4'd5, 4'd3, 4'd1, 4'd8, 4'd8};
      int   len;
      logic s1;
      for (int i = 0; i < 7; i++) begin
         next_phase(req_at[i], len, s1);
         checks++; if (len !== exp_len[i])        begin errors++; $display("FAIL single_len[%0d]: got %0d expected %0d", i, len, exp_len[i]); end
         checks++; if (main_light !== exp_m[i])   begin errors++; $display("FAIL single_main[%0d]: got %b expected %b", i, main_light, exp_m[i]); end
         checks++; if (side_light !== exp_s[i])   begin errors++; $display("FAIL single_side[%0d]: got %b expected %b", i, side_light, exp_s[i]); end
         checks++; if (timer_value !== exp_v[i])  begin errors++; $display("FAIL single_value[%0d]: got %0d expected %0d", i, timer_value, exp_v[i]); end
      end
   endtask

   // A request sampled on the very edge that enters SIDE_GREEN is absorbed by the clear.
   task automatic test_request_on_entry();
      int         req_at [7] = '{2, 0, 3, 0, 0, 0, 0};
      int         exp_len[7] = '{10, 5, 3, 7, 5, 3, 10};
      logic [2:0] exp_m  [7] = '{Y, R, R, R, R, G, G};
      logic [2:0] exp_s  [7] = '{R, R, G, Y, R, R, R};
      int   len;
      logic s1;
      for (int i = 0; i < 7; i++) begin
         next_phase(req_at[i], len, s1);
         checks++; if (len !== exp_len[i])      begin errors++; $display("FAIL entry_len[%0d]: got %0d expected %0d", i, len, exp_len[i]); end
         checks++; if (main_light !== exp_m[i]) begin errors++; $display("FAIL entry_main[%0d]: got %b expected %b", i, main_light, exp_m[i]); end
         checks++; if (side_light !== exp_s[i]) begin errors++; $display("FAIL entry_side[%0d]: got %b expected %b", i, side_light, exp_s[i]); end
      end
   endtask

   // A request raised in SIDE_YELLOW is retained and earns a second side cycle.
   task automatic test_back_to_back();
      int         req_at [13] = '{2, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
      int         exp_len[13] = '{10, 5, 3, 7, 5, 3, 10, 5, 3, 7, 5, 3, 10};
      logic [2:0] exp_m  [13] = '{Y, R, R, R, R, G, Y, R, R, R, R, G, G};
      logic [2:0] exp_s  [13] = '{R, R, G, Y, R, R, R, R, G, Y, R, R, R};
      int   len;
      logic s1;
      for (int i = 0; i < 13; i++) begin
         next_phase(req_at[i], len, s1);
         checks++; if (len !== exp_len[i])      begin errors++; $display("FAIL b2b_len[%0d]: got %0d expected %0d", i, len, exp_len[i]); end
         checks++; if (main_light !== exp_m[i]) begin errors++; $display("FAIL b2b_main[%0d]: got %b expected %b", i, main_light, exp_m[i]); end
         checks++; if (side_light !== exp_s[i]) begin errors++; $display("FAIL b2b_side[%0d]: got %b expected %b", i, side_light, exp_s[i]); end
      end
   endtask

   task automatic test_reset_mid_phase();
      int   len;
      logic s1;
      next_phase(2, len, s1);   // -> MAIN_YELLOW
      next_phase(0, len, s1);   // -> ALL_RED_1
      next_phase(0, len, s1);   // -> SIDE_GREEN (cycle 1 is ARM)
      step();
      step();                   // now in cycle 3 of SIDE_GREEN
      checks++; if (side_light !== G) begin errors++; $display("FAIL midrst_pre_side: got %b expected %b", side_light, G); end
      #2 reset = 1'b1;
      #1;
      checks++; if (side_light !== R)     begin errors++; $display("FAIL midrst_side: got %b expected %b", side_light, R); end
      checks++; if (main_light !== R)     begin errors++; $display("FAIL midrst_main: got %b expected %b", main_light, R); end
      checks++; if (start_timer !== 1'b1) begin errors++; $display("FAIL midrst_start: got %b expected 1", start_timer); end
      checks++; if (timer_value !== 4'd1) begin errors++; $display("FAIL midrst_value: got %0d expected 1", timer_value); end
      repeat (3) step();
      unsafe_cycles = 0;
      side_nonred = 0;
      reset = 1'b0;
      next_phase(0, len, s1);
      checks++; if (len !== 3)        begin errors++; $display("FAIL midrst_first_len: got %0d expected 3", len); end
      checks++; if (main_light !== G) begin errors++; $display("FAIL midrst_first_main: got %b expected %b", main_light, G); end
      for (int i = 0; i < 3; i++) begin
         next_phase(0, len, s1);
         checks++; if (len !== 10)       begin errors++; $display("FAIL midrst_len[%0d]: got %0d expected 10", i, len); end
         checks++; if (main_light !== G) begin errors++; $display("FAIL midrst_main[%0d]: got %b expected %b", i, main_light, G); end
      end
      checks++; if (side_nonred !== 0) begin errors++; $display("FAIL midrst_side_nonred: got %0d expected 0", side_nonred); end
   endtask

   // With expired held high (ARM included), every phase takes ARM plus one WAIT edge.
   task automatic test_expired_forced();
      logic [2:0] seq_m[6] = '{G, Y, R, R, R, R};
      logic [2:0] seq_s[6] = '{R, R, R, G, Y, R};
      int   len;
      logic s1;
      reset = 1'b1;
      step();
      step();
      force_mode = 1'b1;
      forced_exp = 1'b1;
      hold_req = 1'b1;
      side_request = 1'b1;
      unsafe_cycles = 0;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         next_phase(0, len, s1);
         checks++; if (len !== 2)                 begin errors++; $display("FAIL forced_len[%0d]: got %0d expected 2", i, len); end
         checks++; if (s1 !== 1'b0)               begin errors++; $display("FAIL forced_start_wait[%0d]: got %b expected 0", i, s1); end
         checks++; if (main_light !== seq_m[i%6]) begin errors++; $display("FAIL forced_main[%0d]: got %b expected %b", i, main_light, seq_m[i%6]); end
         checks++; if (side_light !== seq_s[i%6]) begin errors++; $display("FAIL forced_side[%0d]: got %b expected %b", i, side_light, seq_s[i%6]); end
      end
      checks++; if (unsafe_cycles !== 0) begin errors++; $display("FAIL forced_unsafe: got %0d expected 0", unsafe_cycles); end
      force_mode = 1'b0;
      hold_req = 1'b0;
      side_request = 1'b0;
   endtask

   initial begin
      test_reset();
      test_no_request();
      test_single_request();
      test_request_on_entry();
      test_back_to_back();
      test_reset_mid_phase();
      test_expired_forced();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
